// File: rtl/spi_link_layer_if.sv
// Push/pop handshake between the SPI link layer and its payload/reply buffers.
// The link layer drives the requests (master); the buffer side answers (slave).
interface spi_link_layer_if;
   logic [15:0] push_data;
   logic        push_request;
   logic        push_done;
   logic        pop_request;
   logic [15:0] pop_data;
   logic        pop_done;

   modport master (
      output push_data, push_request, pop_request,
      input  push_done, pop_data, pop_done
   );

   modport slave (
      input  push_data, push_request, pop_request,
      output push_done, pop_data, pop_done
   );
endinterface

// File: rtl/spi_link_layer.sv
// SPI-slave link layer: deserialises 16-bit SPI words into service packets,
// pushes SEND_DATA payload downstream, checks the checksum, shifts reply words out.
module spi_link_layer (
   input  logic             clk,
   input  logic             nRst,
   input  logic             spi_nCS,
   input  logic             spi_sck,
   input  logic             spi_mosi,
   output logic             spi_miso,
   spi_link_layer_if.master bus,
   output logic [7:0]       inAddr,
   output logic [7:0]       inSize,
   output logic [7:0]       inCmdCode,
   output logic [7:0]       inWordNum,
   output logic             inPacketStart,
   output logic             inPacketEnd,
   output logic             inPacketErr,
   input  logic             outEnable,
   input  logic [7:0]       outAddr
);

   typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_DATA, ST_CHECK, ST_WNUM} state_t;
   typedef enum logic [7:0] {
      CMD_UNKNOWN   = 8'h00,
      CMD_RESET     = 8'hA0,
      CMD_SEND_DATA = 8'hA2,
      CMD_RECV_STS  = 8'hB0,
      CMD_RECV_DATA = 8'hB2
   } cmd_t;

   logic [1:0]  ncs_sync_q;
   logic [2:0]  sck_sync_q;
   logic [1:0]  mosi_sync_q;
   logic [3:0]  bit_cnt_q;
   logic [14:0] rx_sh_q;
   logic [15:0] rx_word_q;
   logic [1:0]  word_pipe_q;

   state_t      state_q;
   cmd_t        cmd_q;
   cmd_t        cmd_d;
   logic [7:0]  inAddr_q;
   logic [7:0]  inSize_q;
   logic [7:0]  inWordNum_q;
   logic        wnum_inc_q;
   logic [15:0] sum_q;
   logic        start_q;
   logic        end_q;
   logic        err_q;
   logic [15:0] push_data_q;
   logic        push_request_q;
   logic        pop_request_q;

   logic [15:0] tx_q;
   logic        pop_wait_q;
   logic [15:0] reply_sum_q;

   logic        ncs_s;
   logic        mosi_s;
   logic        sck_rise;
   logic        sck_fall;
   logic        word_done;
   logic [7:0]  hdr_size;
   logic        hdr_reply;
   logic        pkt_reply;
   logic        last_data;
   logic        enter_check;
   logic        pop_go;
   logic        pkt_accept;
   logic [15:0] sum_d;
   logic [15:0] check_word_d;
   logic        unused_push_done;

   // Downstream ack is accepted but ignored: there is no backpressure.
   assign unused_push_done = bus.push_done;

   assign ncs_s     = ncs_sync_q[1];
   assign mosi_s    = mosi_sync_q[1];
   assign sck_rise  = sck_sync_q[1] & ~sck_sync_q[2];
   assign sck_fall  = ~sck_sync_q[1] & sck_sync_q[2];
   assign word_done = word_pipe_q[1];

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         ncs_sync_q  <= '1;
         sck_sync_q  <= '0;
         mosi_sync_q <= '0;
         bit_cnt_q   <= '0;
         rx_sh_q     <= '0;
         rx_word_q   <= '0;
         word_pipe_q <= '0;
      end else begin
         ncs_sync_q  <= {ncs_sync_q[0], spi_nCS};
         sck_sync_q  <= {sck_sync_q[1:0], spi_sck};
         mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
         word_pipe_q <= {word_pipe_q[0], 1'b0};
         if (ncs_s) begin
            bit_cnt_q <= '0;
         end else if (sck_rise) begin
            rx_sh_q   <= {rx_sh_q[13:0], mosi_s};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
               rx_word_q      <= {rx_sh_q, mosi_s};
               word_pipe_q[0] <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      case (rx_word_q[7:0])
         8'hA0:   cmd_d = CMD_RESET;
         8'hA2:   cmd_d = CMD_SEND_DATA;
         8'hB0:   cmd_d = CMD_RECV_STS;
         8'hB2:   cmd_d = CMD_RECV_DATA;
         default: cmd_d = CMD_UNKNOWN;
      endcase
   end

   assign hdr_size     = rx_word_q[15:8];
   assign hdr_reply    = (cmd_d == CMD_RECV_STS) || (cmd_d == CMD_RECV_DATA);
   assign pkt_reply    = (cmd_q == CMD_RECV_STS) || (cmd_q == CMD_RECV_DATA);
   assign last_data    = (inWordNum_q == inSize_q - 8'd1);
   assign enter_check  = ((state_q == ST_HDR) && (hdr_size == 8'd0)) ||
                         ((state_q == ST_DATA) && last_data);
   assign pop_go       = word_done &&
                         (((state_q == ST_HDR) && hdr_reply && (hdr_size != 8'd0)) ||
                          ((state_q == ST_DATA) && pkt_reply && !last_data));
   assign pkt_accept   = word_done && (state_q == ST_IDLE) && (rx_word_q != '0);
   assign sum_d        = sum_q + rx_word_q;
   assign check_word_d = {outAddr, 8'h00} + reply_sum_q;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q        <= ST_IDLE;
         cmd_q          <= CMD_UNKNOWN;
         inAddr_q       <= '0;
         inSize_q       <= '0;
         inWordNum_q    <= '0;
         wnum_inc_q     <= 1'b0;
         sum_q          <= '0;
         start_q        <= 1'b0;
         end_q          <= 1'b0;
         err_q          <= 1'b0;
         push_data_q    <= '0;
         push_request_q <= 1'b0;
         pop_request_q  <= 1'b0;
      end else begin
         start_q        <= 1'b0;
         end_q          <= 1'b0;
         err_q          <= 1'b0;
         push_request_q <= 1'b0;
         pop_request_q  <= pop_go;
         // Word index is bumped the cycle after the strobe so the strobe carries the old index.
         if (wnum_inc_q) begin
            inWordNum_q <= inWordNum_q + 8'd1;
            wnum_inc_q  <= 1'b0;
         end
         if (word_done) begin
            case (state_q)
               ST_IDLE: begin
                  if (rx_word_q != '0) begin
                     inAddr_q <= rx_word_q[15:8];
                     sum_q    <= rx_word_q;
                     state_q  <= ST_HDR;
                  end
               end
               ST_HDR: begin
                  inSize_q    <= hdr_size;
                  cmd_q       <= cmd_d;
                  start_q     <= 1'b1;
                  inWordNum_q <= '0;
                  sum_q       <= sum_d;
                  state_q     <= (hdr_size == 8'd0) ? ST_CHECK : ST_DATA;
               end
               ST_DATA: begin
                  sum_q      <= sum_d;
                  wnum_inc_q <= 1'b1;
                  if (cmd_q == CMD_SEND_DATA) begin
                     push_data_q    <= rx_word_q;
                     push_request_q <= 1'b1;
                  end
                  if (last_data) state_q <= ST_CHECK;
               end
               ST_CHECK: begin
                  end_q   <= (rx_word_q == sum_q);
                  err_q   <= (rx_word_q != sum_q);
                  state_q <= ST_WNUM;
               end
               ST_WNUM: begin
                  cmd_q   <= CMD_UNKNOWN;
                  state_q <= ST_IDLE;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   // A popped word is only taken while its slot has not yet seen a rising sck edge.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         tx_q        <= '0;
         pop_wait_q  <= 1'b0;
         reply_sum_q <= '0;
      end else begin
         if (pkt_accept) reply_sum_q <= '0;
         if (word_done) begin
            tx_q       <= enter_check ? check_word_d : '0;
            pop_wait_q <= pop_go;
         end else begin
            if (pop_wait_q && bus.pop_done) begin
               pop_wait_q <= 1'b0;
               if (outEnable) begin
                  tx_q        <= bus.pop_data;
                  reply_sum_q <= reply_sum_q + bus.pop_data;
               end
            end else if (sck_rise) begin
               pop_wait_q <= 1'b0;
            end
            if (!ncs_s && sck_fall && (bit_cnt_q != 4'd0)) tx_q <= {tx_q[14:0], 1'b0};
         end
      end
   end

   assign spi_miso         = tx_q[15];
   assign bus.push_data    = push_data_q;
   assign bus.push_request = push_request_q;
   assign bus.pop_request  = pop_request_q;
   assign inAddr           = inAddr_q;
   assign inSize           = inSize_q;
   assign inCmdCode        = cmd_q;
   assign inWordNum        = inWordNum_q;
   assign inPacketStart    = start_q;
   assign inPacketEnd      = end_q;
   assign inPacketErr      = err_q;

endmodule

// File: tb/tb_spi_link_layer.sv
// Directed bench for spi_link_layer: SPI mode-0 master driver, pop responder,
// event monitor and hand-computed expectations.
module tb_spi_link_layer;

   logic       clk = 1'b0;
   logic       nRst;
   logic       spi_nCS;
   logic       spi_sck;
   logic       spi_mosi;
   logic       spi_miso;
   logic [7:0] inAddr;
   logic [7:0] inSize;
   logic [7:0] inCmdCode;
   logic [7:0] inWordNum;
   logic       inPacketStart;
   logic       inPacketEnd;
   logic       inPacketErr;
   logic       outEnable;
   logic [7:0] outAddr;

   always #5 clk = ~clk;

   spi_link_layer_if bus ();

   spi_link_layer dut (
      .clk           (clk),
      .nRst          (nRst),
      .spi_nCS       (spi_nCS),
      .spi_sck       (spi_sck),
      .spi_mosi      (spi_mosi),
      .spi_miso      (spi_miso),
      .bus           (bus.master),
      .inAddr        (inAddr),
      .inSize        (inSize),
      .inCmdCode     (inCmdCode),
      .inWordNum     (inWordNum),
      .inPacketStart (inPacketStart),
      .inPacketEnd   (inPacketEnd),
      .inPacketErr   (inPacketErr),
      .outEnable     (outEnable),
      .outAddr       (outAddr)
   );

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Event monitor, sampled mid-cycle.
   int unsigned start_cnt = 0, end_cnt = 0, err_cnt = 0, push_cnt = 0;
   logic [7:0]  start_addr = '0, start_cmd = '0, start_size = '0;
   logic [15:0] push_d_log [256];
   logic [7:0]  push_n_log [256];

   always @(negedge clk) begin
      if (inPacketStart) begin
         start_cnt++;
         start_addr = inAddr;
         start_cmd  = inCmdCode;
         start_size = inSize;
      end
      if (inPacketEnd) end_cnt++;
      if (inPacketErr) err_cnt++;
      if (bus.push_request) begin
         if (push_cnt < 256) begin
            push_d_log[push_cnt] = bus.push_data;
            push_n_log[push_cnt] = inWordNum;
         end
         push_cnt++;
      end
   end

   // Reply buffer: the n-th pop returns the value n.
   int unsigned pop_cnt = 0;
   initial begin
      bus.pop_done  = 1'b0;
      bus.pop_data  = '0;
      bus.push_done = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.pop_request === 1'b1) begin
            pop_cnt++;
            @(negedge clk);
            bus.pop_data = pop_cnt[15:0];
            bus.pop_done = 1'b1;
            @(negedge clk);
            bus.pop_done = 1'b0;
         end
      end
   end

   initial begin
      repeat (80000) @(posedge clk);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   logic [15:0] pkt_q [$];
   logic [15:0] miso_q [$];
   int unsigned s_start, s_end, s_err, s_push, s_pop;

   task automatic snap();
      s_start = start_cnt;
      s_end   = end_cnt;
      s_err   = err_cnt;
      s_push  = push_cnt;
      s_pop   = pop_cnt;
   endtask

   task automatic spi_xfer(input logic [15:0] w, output logic [15:0] r);
      for (int unsigned i = 0; i < 16; i++) begin
         spi_mosi = w[15-i];
         repeat (8) @(negedge clk);
         r[15-i] = spi_miso;
         spi_sck = 1'b1;
         repeat (8) @(negedge clk);
         spi_sck = 1'b0;
      end
      repeat (16) @(negedge clk);
   endtask

   task automatic send_pkt();
      logic [15:0] r;
      miso_q.delete();
      spi_nCS = 1'b0;
      repeat (8) @(negedge clk);
      foreach (pkt_q[i]) begin
         spi_xfer(pkt_q[i], r);
         miso_q.push_back(r);
      end
      spi_nCS = 1'b1;
      repeat (16) @(negedge clk);
   endtask

   logic [15:0] t1_pay [8] = '{16'hFFA1, 16'h0001, 16'hFFA3, 16'h0002,
                               16'hFFA3, 16'hAB45, 16'hFFA3, 16'hFFA1};
   logic [15:0] r_dummy;
   logic [15:0] exp_sum;

   initial begin
      nRst      = 1'b0;
      spi_nCS   = 1'b1;
      spi_sck   = 1'b0;
      spi_mosi  = 1'b0;
      outEnable = 1'b0;
      outAddr   = 8'hAB;
      repeat (5) @(negedge clk);
      check_eq("rst_addr", 32'(inAddr), 32'h00);
      check_eq("rst_size", 32'(inSize), 32'h00);
      check_eq("rst_cmd", 32'(inCmdCode), 32'h00);
      check_eq("rst_wnum", 32'(inWordNum), 32'h00);
      check_eq("rst_strobes", 32'({spi_miso, bus.push_request, bus.pop_request,
                                   inPacketStart, inPacketEnd, inPacketErr}), 32'h0);
      check_eq("rst_pushdata", 32'(bus.push_data), 32'h0000);
      nRst = 1'b1;
      repeat (5) @(negedge clk);

      // SEND_DATA, eight payload words, good checksum
      snap();
      pkt_q = '{16'hAB00, 16'h08A2, 16'hFFA1, 16'h0001, 16'hFFA3, 16'h0002,
                16'hFFA3, 16'hAB45, 16'hFFA3, 16'hFFA1, 16'h5D15, 16'h0000};
      send_pkt();
      check_eq("t1_start", start_cnt - s_start, 1);
      check_eq("t1_start_addr", 32'(start_addr), 32'hAB);
      check_eq("t1_start_cmd", 32'(start_cmd), 32'hA2);
      check_eq("t1_npush", push_cnt - s_push, 8);
      for (int unsigned k = 0; k < 8; k++) begin
         check_eq($sformatf("t1_push_data%0d", k), 32'(push_d_log[s_push+k]), 32'(t1_pay[k]));
         check_eq($sformatf("t1_push_wnum%0d", k), 32'(push_n_log[s_push+k]), k);
      end
      check_eq("t1_end", end_cnt - s_end, 1);
      check_eq("t1_err", err_cnt - s_err, 0);
      check_eq("t1_cmd_after", 32'(inCmdCode), 32'h00);
      check_eq("t1_addr_hold", 32'(inAddr), 32'hAB);
      check_eq("t1_size_hold", 32'(inSize), 32'h08);

      // Same packet with a bad checksum
      snap();
      pkt_q[10] = 16'h5D10;
      send_pkt();
      check_eq("t2_err", err_cnt - s_err, 1);
      check_eq("t2_end", end_cnt - s_end, 0);
      check_eq("t2_npush", push_cnt - s_push, 8);
      check_eq("t2_cmd_after", 32'(inCmdCode), 32'h00);

      // RECEIVE_DATA, ten reply words
      snap();
      outEnable = 1'b1;
      pkt_q = '{16'hAB00, 16'h0AB2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hB5B2, 16'h0000};
      send_pkt();
      check_eq("t3_start_cmd", 32'(start_cmd), 32'hB2);
      check_eq("t3_start_size", 32'(start_size), 32'h0A);
      check_eq("t3_npop", pop_cnt - s_pop, 10);
      check_eq("t3_miso_w0", 32'(miso_q[0]), 32'h0000);
      check_eq("t3_miso_w1", 32'(miso_q[1]), 32'h0000);
      exp_sum = 16'hAB00;
      for (int unsigned k = 0; k < 10; k++) begin
         check_eq($sformatf("t3_miso_pay%0d", k), 32'(miso_q[2+k]), s_pop + k + 1);
         exp_sum = exp_sum + 16'(s_pop + k + 1);
      end
      check_eq("t3_miso_check", 32'(miso_q[12]), 32'(exp_sum));
      check_eq("t3_miso_wnum", 32'(miso_q[13]), 32'h0000);
      check_eq("t3_end", end_cnt - s_end, 1);
      check_eq("t3_npush", push_cnt - s_push, 0);

      // RECEIVE_STS, zero-length packet
      snap();
      pkt_q = '{16'hAB00, 16'h00B0, 16'hABB0, 16'h0000};
      send_pkt();
      check_eq("t4_start_cmd", 32'(start_cmd), 32'hB0);
      check_eq("t4_size", 32'(inSize), 32'h00);
      check_eq("t4_end", end_cnt - s_end, 1);
      check_eq("t4_npush", push_cnt - s_push, 0);
      check_eq("t4_npop", pop_cnt - s_pop, 0);
      check_eq("t4_miso_check", 32'(miso_q[2]), 32'hAB00);

      // Reply with outEnable low: payload slots and reply sum stay zero
      snap();
      outEnable = 1'b0;
      pkt_q = '{16'hAB00, 16'h02B0, 16'h0000, 16'h0000, 16'hADB0, 16'h0000};
      send_pkt();
      check_eq("t5_npop", pop_cnt - s_pop, 2);
      check_eq("t5_miso_pay0", 32'(miso_q[2]), 32'h0000);
      check_eq("t5_miso_pay1", 32'(miso_q[3]), 32'h0000);
      check_eq("t5_miso_check", 32'(miso_q[4]), 32'hAB00);
      check_eq("t5_end", end_cnt - s_end, 1);

      // RESET command, two addresses
      snap();
      pkt_q = '{16'h0100, 16'h00A0, 16'h01A0, 16'h0000};
      send_pkt();
      check_eq("t6_addr01", 32'(start_addr), 32'h01);
      check_eq("t6_cmd01", 32'(start_cmd), 32'hA0);
      check_eq("t6_end01", end_cnt - s_end, 1);
      snap();
      pkt_q = '{16'hAB00, 16'h00A0, 16'hABA0, 16'h0000};
      send_pkt();
      check_eq("t6_addrAB", 32'(start_addr), 32'hAB);
      check_eq("t6_cmdAB", 32'(start_cmd), 32'hA0);
      check_eq("t6_endAB", end_cnt - s_end, 1);

      // Filler words alone produce no events
      snap();
      pkt_q = '{16'h0000, 16'h0000};
      send_pkt();
      check_eq("t7_filler_events", (start_cnt - s_start) + (end_cnt - s_end) + (err_cnt - s_err), 0);
      check_eq("t7_filler_addr", 32'(inAddr), 32'hAB);

      // Reset mid-payload
      snap();
      spi_nCS = 1'b0;
      repeat (8) @(negedge clk);
      spi_xfer(16'hAB00, r_dummy);
      spi_xfer(16'h04A2, r_dummy);
      spi_xfer(16'h1111, r_dummy);
      spi_xfer(16'h2222, r_dummy);
      check_eq("t8_wnum_before", 32'(inWordNum), 32'h02);
      nRst = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("t8_rst_addr", 32'(inAddr), 32'h00);
      check_eq("t8_rst_size", 32'(inSize), 32'h00);
      check_eq("t8_rst_cmd", 32'(inCmdCode), 32'h00);
      check_eq("t8_rst_wnum", 32'(inWordNum), 32'h00);
      check_eq("t8_rst_pushdata", 32'(bus.push_data), 32'h0000);
      spi_nCS = 1'b1;
      nRst = 1'b1;
      repeat (8) @(negedge clk);
      check_eq("t8_no_end_err", (end_cnt - s_end) + (err_cnt - s_err), 0);
      snap();
      pkt_q = '{16'h0100, 16'h00A0, 16'h01A0, 16'h0000};
      send_pkt();
      check_eq("t8_recover_end", end_cnt - s_end, 1);
      check_eq("t8_recover_addr", 32'(inAddr), 32'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
